// File: rtl/tx_fifo_feeder.sv
// tx_fifo_feeder: circular byte FIFO in front of the UART transmitter.
// The system side pushes bytes; a small sequencer hands them to the
// transmitter one at a time and waits for its done pulse between bytes.
module tx_fifo_feeder #(
    parameter int NB_DATA = 8,
    parameter int NB_ADDR = 3
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_wr,
    input  logic [NB_DATA-1:0] i_wr_data,
    output logic               o_full,
    output logic               o_empty,
    output logic [NB_ADDR:0]   o_count,
    output logic               o_overflow,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    input  logic               i_tx_done,
    output logic               o_busy
);

    localparam int DEPTH = 2 ** NB_ADDR;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_WAIT  = 2'b10
    } state_e;

    logic [NB_DATA-1:0] mem_q [DEPTH];
    logic [NB_ADDR-1:0] wrPtr_q, wrPtr_d;
    logic [NB_ADDR-1:0] rdPtr_q, rdPtr_d;
    logic [NB_ADDR:0]   count_q, count_d;
    state_e             state_q, state_d;
    logic [NB_DATA-1:0] txData_q, txData_d;
    logic               overflow_q, overflow_d;
    logic               full, empty, wrAccept, pop;

    // Occupancy flags, write acceptance and the pop decision all come from
    // registered state, so a write while full is dropped even if a pop
    // happens on the same edge.
    always_comb begin
        full     = (count_q == (NB_ADDR+1)'(DEPTH));
        empty    = (count_q == '0);
        wrAccept = i_wr && !full;
        pop      = (state_q == ST_IDLE) && !empty;
    end

    // Pointer, count, overflow and transmit-byte next-state logic.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        txData_d   = txData_q;
        if (wrAccept) begin
            wrPtr_d = wrPtr_q + NB_ADDR'(1);
        end
        if (pop) begin
            rdPtr_d  = rdPtr_q + NB_ADDR'(1);
            txData_d = mem_q[rdPtr_q];
        end
        case ({wrAccept, pop})
            2'b10:   count_d = count_q + (NB_ADDR+1)'(1);
            2'b01:   count_d = count_q - (NB_ADDR+1)'(1);
            default: count_d = count_q;
        endcase
        if (i_wr && full) begin
            overflow_d = 1'b1;
        end
    end

    // Sequencer: IDLE pops a byte, START pulses once, WAIT holds for done.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:  state_d = pop ? ST_START : ST_IDLE;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  state_d = i_tx_done ? ST_IDLE : ST_WAIT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Control registers; reset makes queued bytes unreachable but does not
    // clear the storage array.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            txData_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            txData_q   <= txData_d;
            overflow_q <= overflow_d;
        end
    end

    // Byte storage, written only on accepted pushes.
    always_ff @(posedge i_clk) begin
        if (wrAccept) begin
            mem_q[wrPtr_q] <= i_wr_data;
        end
    end

    // Moore outputs straight from registered state.
    always_comb begin
        o_full     = full;
        o_empty    = empty;
        o_count    = count_q;
        o_overflow = overflow_q;
        o_tx_start = (state_q == ST_START);
        o_busy     = (state_q == ST_START) || (state_q == ST_WAIT);
        o_tx_data  = txData_q;
    end

endmodule
